// File: rtl/axi_pkg.sv
// Shared AXI encodings, slave register map and the line-fetch FSM state type.
package axi_pkg;

  // AXI field encodings used by the line fetcher.
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Register offsets of the camera-side slave, relative to its base address.
  localparam logic [31:0] INT_STATUS = 32'h0000_0000;
  localparam logic [31:0] FIFO1_READ = 32'h0000_0004;
  localparam logic [31:0] FIFO2_READ = 32'h0000_0008;

  // Line-fetch sequencer states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ST_AR = 3'd1,
    ST_R  = 3'd2,
    F_AR  = 3'd3,
    F_R   = 3'd4,
    CLR   = 3'd5,
    CLR_B = 3'd6,
    HOLD  = 3'd7
  } fsm_state_e;

endpackage

// File: rtl/axi_burst_splitter.sv
// Splits the pixels still owed for one FIFO into INCR bursts of at most
// 16 beats and flags the final beat of the burst in flight.
module axi_burst_splitter #(
  parameter int CW = 10
) (
  input  logic [CW-1:0] remaining_i,
  input  logic [4:0]    beats_left_i,
  output logic [3:0]    arlen_o,
  output logic          last_beat_o
);

  logic [31:0] rem_ext_s;

  // Burst length is the smaller of 16 and what is left of the line.
  always_comb begin
    rem_ext_s = 32'(remaining_i);
    if (rem_ext_s >= 32'd16) begin
      arlen_o = 4'hf;
    end else if (rem_ext_s == 32'd0) begin
      arlen_o = 4'h0;
    end else begin
      arlen_o = rem_ext_s[3:0] - 4'd1;
    end
  end

  // The beat counter, not rlast, decides where a burst ends.
  assign last_beat_o = (beats_left_i == 5'd1);

endmodule

// File: rtl/axi_line_fetch_master.sv
// Interrupt-driven line fetcher: reads INT_STATUS, drains both pixel FIFOs
// through bounded INCR bursts into the CNN buffer, then clears the interrupt.
module axi_line_fetch_master
  import axi_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    ID_MAX_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] OFFSET_ADDR  = 32'h000f_0000,
  parameter int                    LINE_WORDS   = 640,
  parameter int                    MASTER_ID    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_interrupt,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [3:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [ID_MAX_WIDTH-1:0] arid,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic [ID_MAX_WIDTH-1:0] rid,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [3:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [ID_MAX_WIDTH-1:0] awid,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic [ID_MAX_WIDTH-1:0] wid,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic [ID_MAX_WIDTH-1:0] bid,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [15:0]             o_pix_data,
  output logic                    o_pix_src,
  output logic                    o_pix_valid,
  input  logic                    i_pix_ready,
  output logic                    o_busy,
  output logic                    o_line_done,
  output logic                    o_err
);

  localparam int                      CW       = $clog2(LINE_WORDS + 1);
  localparam logic [CW-1:0]           LINE_CNT = CW'(LINE_WORDS);
  localparam logic [ID_MAX_WIDTH-1:0] ID_VAL   = ID_MAX_WIDTH'(MASTER_ID);

  fsm_state_e            state_q, state_d;
  logic                  src_q, src_d;
  logic [CW-1:0]         remaining_q, remaining_d;
  logic [4:0]            beats_left_q, beats_left_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [1:0]            hold_cnt_q, hold_cnt_d;
  logic                  err_q, err_d;
  logic                  line_done_q, line_done_d;

  logic [3:0]            burst_arlen_s;
  logic                  last_beat_s;

  axi_burst_splitter #(
    .CW (CW)
  ) u_splitter (
    .remaining_i  (remaining_q),
    .beats_left_i (beats_left_q),
    .arlen_o      (burst_arlen_s),
    .last_beat_o  (last_beat_s)
  );

  // Fields that never change across transactions.
  assign arsize      = SIZE_4B;
  assign arburst     = BURST_INCR;
  assign arid        = ID_VAL;
  assign awaddr      = OFFSET_ADDR + ADDR_WIDTH'(INT_STATUS);
  assign awlen       = 4'h0;
  assign awsize      = SIZE_4B;
  assign awburst     = BURST_INCR;
  assign awid        = ID_VAL;
  assign wdata       = wdata_q;
  assign wstrb       = 4'hf;
  assign wlast       = 1'b1;
  assign wid         = ID_VAL;
  assign o_busy      = (state_q != IDLE);
  assign o_line_done = line_done_q;
  assign o_err       = err_q;

  // Next-state, channel handshakes and the zero-latency pixel pass-through.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    remaining_d  = remaining_q;
    beats_left_d = beats_left_q;
    wdata_d      = wdata_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    hold_cnt_d   = hold_cnt_q;
    err_d        = err_q;
    line_done_d  = 1'b0;
    araddr       = OFFSET_ADDR + ADDR_WIDTH'(INT_STATUS);
    arlen        = 4'h0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    o_pix_valid  = 1'b0;
    o_pix_data   = rdata[15:0];
    o_pix_src    = src_q;

    case (state_q)
      IDLE: begin
        if (i_interrupt) begin
          state_d = ST_AR;
        end else begin
          state_d = IDLE;
        end
      end

      ST_AR: begin
        arvalid = 1'b1;
        if (arready) begin
          state_d = ST_R;
        end else begin
          state_d = ST_AR;
        end
      end

      ST_R: begin
        rready = 1'b1;
        if (rvalid) begin
          // A single-beat read must carry rlast.
          if ((rresp != RESP_OKAY) || (rid != ID_VAL) || !rlast) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (rdata[0]) begin
            state_d     = F_AR;
            src_d       = 1'b0;
            remaining_d = LINE_CNT;
          end else begin
            // Nothing to fetch, but the status value is still written back.
            state_d   = CLR;
            wdata_d   = rdata;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end
        end else begin
          state_d = ST_R;
        end
      end

      F_AR: begin
        arvalid = 1'b1;
        araddr  = src_q ? (OFFSET_ADDR + ADDR_WIDTH'(FIFO2_READ))
                        : (OFFSET_ADDR + ADDR_WIDTH'(FIFO1_READ));
        arlen   = burst_arlen_s;
        if (arready) begin
          beats_left_d = {1'b0, burst_arlen_s} + 5'd1;
          state_d      = F_R;
        end else begin
          state_d = F_AR;
        end
      end

      F_R: begin
        rready      = i_pix_ready;
        o_pix_valid = rvalid;
        if (rvalid && i_pix_ready) begin
          remaining_d  = remaining_q - CW'(1);
          beats_left_d = beats_left_q - 5'd1;
          if ((rresp != RESP_OKAY) || (rid != ID_VAL) || (rlast != last_beat_s)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (!last_beat_s) begin
            state_d = F_R;
          end else if (remaining_q != CW'(1)) begin
            state_d = F_AR;
          end else if (!src_q) begin
            src_d       = 1'b1;
            remaining_d = LINE_CNT;
            state_d     = F_AR;
          end else begin
            state_d   = CLR;
            wdata_d   = DATA_WIDTH'(32'd1);
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end
        end else begin
          state_d = F_R;
        end
      end

      CLR: begin
        // AW and W are independent; each drops on its own handshake.
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        if (awvalid && awready) begin
          aw_done_d = 1'b1;
        end else begin
          aw_done_d = aw_done_q;
        end
        if (wvalid && wready) begin
          w_done_d = 1'b1;
        end else begin
          w_done_d = w_done_q;
        end
        if (aw_done_d && w_done_d) begin
          state_d = CLR_B;
        end else begin
          state_d = CLR;
        end
      end

      CLR_B: begin
        bready = 1'b1;
        if (bvalid) begin
          if ((bresp != RESP_OKAY) || (bid != ID_VAL)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          line_done_d = 1'b1;
          hold_cnt_d  = 2'd0;
          state_d     = HOLD;
        end else begin
          state_d = CLR_B;
        end
      end

      HOLD: begin
        // Give the slave time to drop the interrupt before re-arming.
        if (hold_cnt_q == 2'd2) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 2'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      src_q        <= 1'b0;
      remaining_q  <= '0;
      beats_left_q <= 5'd0;
      wdata_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      hold_cnt_q   <= 2'd0;
      err_q        <= 1'b0;
      line_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      remaining_q  <= remaining_d;
      beats_left_q <= beats_left_d;
      wdata_q      <= wdata_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      hold_cnt_q   <= hold_cnt_d;
      err_q        <= err_d;
      line_done_q  <= line_done_d;
    end
  end

endmodule

// File: tb/tb_axi_line_fetch_master.sv
// Directed bench for axi_line_fetch_master with a small behavioural AXI slave.
module tb_axi_line_fetch_master;

  localparam int          LW   = 20;
  localparam logic [31:0] BASE = 32'h000f_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_interrupt;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [15:0] arid;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [15:0] rid;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [15:0] awid;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic [15:0] wid;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic [15:0] bid;
  logic        bvalid, bready;
  logic [15:0] o_pix_data;
  logic        o_pix_src, o_pix_valid, i_pix_ready;
  logic        o_busy, o_line_done, o_err;

  axi_line_fetch_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_MAX_WIDTH(16),
    .OFFSET_ADDR(BASE), .LINE_WORDS(LW), .MASTER_ID(1)
  ) dut (
    .clk(clk), .rst(rst), .i_interrupt(i_interrupt),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arid(arid), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid),
    .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awid(awid), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wid(wid),
    .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bid(bid), .bvalid(bvalid), .bready(bready),
    .o_pix_data(o_pix_data), .o_pix_src(o_pix_src), .o_pix_valid(o_pix_valid),
    .i_pix_ready(i_pix_ready), .o_busy(o_busy), .o_line_done(o_line_done),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] status;
    bit          pix_rand;
    int          aw_dly;
    int          w_dly;
    bit          inject;
    int          exp_ar;
    int          exp_pix;
    logic [31:0] exp_wdata;
    bit          exp_err;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Slave configuration, written by the main sequence only.
  logic [31:0] status_cfg = 32'h0;
  bit          pix_rand_cfg = 1'b0;
  int          aw_dly_cfg = 0;
  int          w_dly_cfg = 0;
  bit          inject_cfg = 1'b0;

  // Slave state and logs, written by the slave process only.
  bit          r_active = 1'b0, r_status = 1'b0, r_src = 1'b0;
  int          r_left = 0, f1_idx = 0, f2_idx = 0, fburst = 0, fbeat = 0, clr_cyc = 0;
  bit          aw_seen = 1'b0, w_seen = 1'b0, b_pend = 1'b0;
  logic [35:0] ar_log[$];
  logic [16:0] pix_log[$];
  int          aw_cnt = 0, w_cnt = 0, ld_cnt = 0, rready_bad = 0, bready_bad = 0;
  logic [31:0] aw_addr_log = 32'h0, w_data_log = 32'h0;

  int ld_base, ar_base, pix_base, aw_base, w_base, rr_base, br_base;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(string nm, logic [31:0] st, bit pr, int awd, int wd, bit inj,
                              int ea, int ep, logic [31:0] ew, bit ee);
    vec_t t;
    t.name = nm; t.status = st; t.pix_rand = pr; t.aw_dly = awd; t.w_dly = wd;
    t.inject = inj; t.exp_ar = ea; t.exp_pix = ep; t.exp_wdata = ew; t.exp_err = ee;
    return t;
  endfunction

  function automatic logic [35:0] exp_ar_ent(int i);
    case (i)
      0:       return {BASE,               4'h0};
      1:       return {BASE + 32'h4,       4'hf};
      2:       return {BASE + 32'h4,       4'h3};
      3:       return {BASE + 32'h8,       4'hf};
      default: return {BASE + 32'h8,       4'h3};
    endcase
  endfunction

  function automatic logic [16:0] exp_pix_ent(int k);
    if (k < LW) return {1'b0, 16'h1000 + 16'(k)};
    else        return {1'b1, 16'h2000 + 16'(k - LW)};
  endfunction

  // Behavioural slave: observes at negedge, drives just after posedge.
  initial begin
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0;
    rid = 16'd1; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    bid = 16'd1; i_pix_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        r_active = 1'b0; r_left = 0; b_pend = 1'b0; aw_seen = 1'b0; w_seen = 1'b0;
        clr_cyc = 0;
      end else begin
        ar_hs = arvalid && arready;
        r_hs  = rvalid && rready;
        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        b_hs  = bvalid && bready;
        if (ar_hs) ar_log.push_back({araddr, arlen});
        if (o_pix_valid && i_pix_ready) pix_log.push_back({o_pix_src, o_pix_data});
        if (rvalid && !r_status && (rready !== i_pix_ready)) rready_bad++;
        if (bready && !(aw_seen && w_seen)) bready_bad++;
        if (o_line_done) ld_cnt++;
        if (aw_hs) begin aw_cnt++; aw_addr_log = awaddr; aw_seen = 1'b1; end
        if (w_hs) begin w_cnt++; w_data_log = wdata; w_seen = 1'b1; end
        if ((aw_hs || w_hs) && aw_seen && w_seen) b_pend = 1'b1;
        if (b_hs) b_pend = 1'b0;
        if (awvalid || wvalid) clr_cyc++;
        if (ar_hs) begin
          r_active = 1'b1;
          r_left   = int'(arlen) + 1;
          r_status = (araddr == BASE);
          r_src    = (araddr == BASE + 32'h8);
          if (r_status) begin
            f1_idx = 0; f2_idx = 0; fburst = 0; fbeat = 0; clr_cyc = 0;
            aw_seen = 1'b0; w_seen = 1'b0;
          end else begin
            fburst++;
          end
        end
        if (r_hs) begin
          r_left--;
          if (!r_status) begin
            fbeat++;
            if (r_src) f2_idx++; else f1_idx++;
          end
          if (r_left == 0) r_active = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      arready = 1'b1;
      rvalid  = r_active;
      if (r_status) rdata = status_cfg;
      else rdata = {16'hA5A5, (r_src ? 16'h2000 : 16'h1000) + 16'(r_src ? f2_idx : f1_idx)};
      rlast   = (r_left == 1) && !(inject_cfg && !r_status && fburst == 2);
      rresp   = (inject_cfg && !r_status && fbeat == 3) ? 2'b10 : 2'b00;
      awready = (clr_cyc >= aw_dly_cfg);
      wready  = (clr_cyc >= w_dly_cfg);
      bvalid  = b_pend;
      i_pix_ready = pix_rand_cfg ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic snap();
    ld_base = ld_cnt; ar_base = ar_log.size(); pix_base = pix_log.size();
    aw_base = aw_cnt; w_base = w_cnt; rr_base = rready_bad; br_base = bready_bad;
  endtask

  task automatic start_line(input vec_t v);
    @(posedge clk); #1;
    status_cfg = v.status; pix_rand_cfg = v.pix_rand; aw_dly_cfg = v.aw_dly;
    w_dly_cfg = v.w_dly; inject_cfg = v.inject;
    snap();
    i_interrupt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({v.name, ":busy"}, 64'(o_busy), 64'd1);
  endtask

  task automatic finish_line(input vec_t v);
    bit seen;
    int n, bad;
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (o_line_done) seen = 1'b1;
    end
    check({v.name, ":done_seen"}, 64'(seen), 64'd1);
    @(posedge clk); #1;
    i_interrupt = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n++;
      if (!o_busy) break;
    end
    check({v.name, ":hold_cycles"}, 64'(n), 64'd3);
    repeat (2) @(posedge clk);
    #1;
    check({v.name, ":ar_count"}, 64'(ar_log.size() - ar_base), 64'(v.exp_ar));
    for (int i = 0; i < v.exp_ar; i++)
      if (ar_base + i < ar_log.size())
        check($sformatf("%s:ar%0d", v.name, i), 64'(ar_log[ar_base + i]), 64'(exp_ar_ent(i)));
    check({v.name, ":pix_count"}, 64'(pix_log.size() - pix_base), 64'(v.exp_pix));
    bad = 0;
    for (int k = 0; k < v.exp_pix; k++)
      if (pix_base + k >= pix_log.size() || pix_log[pix_base + k] !== exp_pix_ent(k)) bad++;
    check({v.name, ":pix_data_errors"}, 64'(bad), 64'd0);
    check({v.name, ":rready_mirror_errors"}, 64'(rready_bad - rr_base), 64'd0);
    check({v.name, ":aw_count"}, 64'(aw_cnt - aw_base), 64'd1);
    check({v.name, ":w_count"}, 64'(w_cnt - w_base), 64'd1);
    check({v.name, ":awaddr"}, 64'(aw_addr_log), 64'(BASE));
    check({v.name, ":wdata"}, 64'(w_data_log), 64'(v.exp_wdata));
    check({v.name, ":bready_early"}, 64'(bready_bad - br_base), 64'd0);
    check({v.name, ":line_done_count"}, 64'(ld_cnt - ld_base), 64'd1);
    check({v.name, ":err"}, 64'(o_err), 64'(v.exp_err));
    check({v.name, ":idle_at_end"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    vec_t vecs[9];
    vec_t rv;
    bit   ar_seen;
    vecs[0] = mk("basic",       32'h1, 1'b0, 0, 0, 1'b0, 5, 40, 32'h1, 1'b0);
    vecs[1] = mk("status0",     32'h0, 1'b0, 0, 0, 1'b0, 1,  0, 32'h0, 1'b0);
    vecs[2] = mk("status2",     32'h2, 1'b0, 0, 0, 1'b0, 1,  0, 32'h2, 1'b0);
    vecs[3] = mk("rand_ready",  32'h1, 1'b1, 0, 0, 1'b0, 5, 40, 32'h1, 1'b0);
    vecs[4] = mk("w_before_aw", 32'h1, 1'b0, 5, 0, 1'b0, 5, 40, 32'h1, 1'b0);
    vecs[5] = mk("aw_w_same",   32'h1, 1'b0, 2, 2, 1'b0, 5, 40, 32'h1, 1'b0);
    vecs[6] = mk("aw_before_w", 32'h1, 1'b0, 0, 3, 1'b0, 5, 40, 32'h1, 1'b0);
    vecs[7] = mk("err_inject",  32'h1, 1'b0, 0, 0, 1'b1, 5, 40, 32'h1, 1'b1);
    vecs[8] = mk("err_sticky",  32'h1, 1'b1, 0, 0, 1'b0, 5, 40, 32'h1, 1'b1);

    rst = 1'b1;
    i_interrupt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valids",
          64'({arvalid, rready, awvalid, wvalid, bready, o_pix_valid, o_busy, o_err, o_line_done}),
          64'd0);
    check("fixed_fields", 64'({arsize, arburst, awsize, awburst, awlen, wlast, wstrb}),
          64'({3'b010, 2'b01, 3'b010, 2'b01, 4'h0, 1'b1, 4'hf}));
    check("ids", 64'({arid, awid, wid}), 64'({16'd1, 16'd1, 16'd1}));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 9; i++) begin
      start_line(vecs[i]);
      finish_line(vecs[i]);
    end

    // Reset in the middle of a FIFO burst, interrupt left high.
    rv = mk("rst_rerun", 32'h1, 1'b0, 0, 0, 1'b0, 5, 40, 32'h1, 1'b0);
    start_line(rv);
    for (int c = 0; c < 200 && (pix_log.size() - pix_base) < 5; c++) @(negedge clk);
    check("rst:pixels_before_reset", 64'((pix_log.size() - pix_base) >= 5), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    snap();
    @(negedge clk);
    check("rst:valids_dropped",
          64'({arvalid, rready, awvalid, wvalid, bready, o_pix_valid, o_busy, o_line_done}),
          64'd0);
    check("rst:err_cleared", 64'(o_err), 64'd0);
    ar_seen = 1'b0;
    for (int c = 0; c < 10 && !ar_seen; c++) begin
      if (arvalid) ar_seen = 1'b1;
      else @(negedge clk);
    end
    check("rst:fresh_ar_seen", 64'(ar_seen), 64'd1);
    check("rst:fresh_ar_fields", 64'({araddr, arlen}), 64'({BASE, 4'h0}));
    finish_line(rv);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop if the sequence ever stalls outside its own bounds.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule

// File: doc/axi_line_fetch_master.md
Name: axi_line_fetch_master

Overview:
- AXI3-style read/write initiator that pairs with the camera-side register/FIFO AXI slave.
- On a line-done interrupt it reads INT_STATUS, then drains LINE_WORDS 16-bit pixels from FIFO1 and then from FIFO2 using INCR bursts of at most 16 beats.
- Pixels are streamed to the CNN input buffer with backpressure; the interrupt is then cleared by a W1C write to INT_STATUS.

Parameters:
- DATA_WIDTH, 32, AXI data width.
- ADDR_WIDTH, 32, AXI address width.
- ID_MAX_WIDTH, 16, AXI ID width.
- OFFSET_ADDR, 32'h000f_0000, slave base address; INT_STATUS is +0x00, FIFO1 +0x04, FIFO2 +0x08.
- LINE_WORDS, 640, pixels per FIFO per line (must be at least 1).
- MASTER_ID, 1, value driven on arid, awid and wid.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_interrupt  in  1  level interrupt from the slave
- araddr/arlen/arsize/arburst/arid/arvalid  out  ADDR_WIDTH/4/3/2/ID_MAX_WIDTH/1  read address channel
- arready  in  1  read address handshake
- rdata/rresp/rlast/rid/rvalid  in  DATA_WIDTH/2/1/ID_MAX_WIDTH/1  read data channel
- rready  out  1  read data handshake
- awaddr/awlen/awsize/awburst/awid/awvalid  out  ADDR_WIDTH/4/3/2/ID_MAX_WIDTH/1  write address channel
- awready  in  1  write address handshake
- wdata/wstrb/wlast/wid/wvalid  out  DATA_WIDTH/4/1/ID_MAX_WIDTH/1  write data channel
- wready  in  1  write data handshake
- bresp/bid/bvalid  in  2/ID_MAX_WIDTH/1  write response channel
- bready  out  1  write response handshake
- o_pix_data  out  16  pixel, rdata[15:0]
- o_pix_src  out  1  source FIFO: 0 = FIFO1, 1 = FIFO2
- o_pix_valid  out  1  pixel valid
- i_pix_ready  in  1  downstream ready
- o_busy  out  1  high whenever the FSM is not in IDLE
- o_line_done  out  1  one-cycle pulse on B accept
- o_err  out  1  sticky error, cleared only by rst

Behaviour:
- Reset: all valid/ready outputs 0, o_err 0, FSM in IDLE, counters 0.
- Fixed AXI fields: arsize = awsize = 3'b010; arburst = awburst = INCR; awlen = 0; wlast = 1; wstrb = 4'hf; all IDs = MASTER_ID.
- FSM states: IDLE, ST_AR, ST_R, F_AR, F_R, CLR, CLR_B, HOLD.
- IDLE: if i_interrupt=1, go to ST_AR.
- ST_AR: araddr = OFFSET_ADDR, arlen = 0, arvalid = 1 until arready; then go to ST_R.
- ST_R: rready = 1; on the rvalid beat, latch r_status = rdata.
  - If r_status[0] = 1: go to F_AR with src = 0 and remaining = LINE_WORDS.
  - Otherwise: go to CLR with wdata = r_status. A zero write is still issued.
- F_AR: araddr = OFFSET_ADDR + (src ? 0x08 : 0x04); arlen = min(remaining, 16) - 1. Hold arvalid and all AR fields stable until arready.
- F_R: rready = i_pix_ready; o_pix_valid = rvalid; o_pix_data = rdata[15:0]; o_pix_src = src. This path is combinational and adds zero latency.
  - Each accepted beat (rvalid & rready) decrements remaining and the beat counter.
  - On the last beat of a burst: if remaining > 0, go to F_AR. If remaining = 0 and src = 0, set src = 1, remaining = LINE_WORDS, go to F_AR. If remaining = 0 and src = 1, go to CLR with wdata = 32'h1.
- CLR: awaddr = OFFSET_ADDR. Assert awvalid and wvalid together; drop each independently on its own handshake (either order, or the same cycle). Go to CLR_B once both are accepted.
- CLR_B: bready = 1; on bvalid, pulse o_line_done and go to HOLD.
- HOLD: wait 3 cycles, covering the slave's interrupt-clear latency, then go to IDLE. This prevents re-triggering on a stale interrupt.
- Error conditions, each setting o_err (sticky), with the FSM continuing normally:
  - rresp != 0 or bresp != 0;
  - rlast = 1 on a non-final beat, or rlast = 0 on the final beat;
  - rid or bid != MASTER_ID.
- The beat count owns burst termination; rlast is checked only.
- i_interrupt is ignored outside IDLE.
- rst asserted mid-burst aborts the transaction immediately; the slave is reset alongside.
- Counters use width $clog2(LINE_WORDS+1); no wrap is possible.

Decomposition:
- Package axi_pkg:
  - BURST_INCR, SIZE_4B, RESP_OKAY;
  - register offsets INT_STATUS, FIFO1_READ, FIFO2_READ (shared with the slave);
  - FSM state enum typedef.
- Sub-module axi_burst_splitter: takes remaining, produces arlen and the last-beat flag.

Test Plan:
- LINE_WORDS = 20, status = 1, slave always ready:
  - FIFO1 bursts of arlen 15 then 3 at 0x000f_0004;
  - FIFO2 bursts of arlen 15 then 3 at 0x000f_0008;
  - 40 pixels out with o_pix_src 0×20 then 1×20;
  - write wdata = 1 to 0x000f_0000;
  - o_line_done pulses once.
- Status read returns 0: no FIFO AR is issued; a write with wdata = 0 is issued; o_line_done pulses.
- i_pix_ready toggles 50% random: rready mirrors i_pix_ready every cycle; no pixel is lost or duplicated (pixel-count and data scoreboard).
- Slave accepts W 5 cycles before AW, and in another run the same cycle: exactly one AW and one W handshake each; CLR_B is entered only after both.
- Slave returns rresp = 2'b10 on beat 3 and drops rlast on a final beat: o_err = 1, the transfer still completes, o_err holds until rst.
- rst asserted mid-F_R for 1 cycle: all valids drop the next cycle; with i_interrupt still high, a fresh ST_AR starts afterward.
